// File: rtl/des_if.sv
// Start/done handshake bundle between a DES client (master) and the des engine (slave).
// Blocks and keys use FIPS bit numbering: bit 1 is the MSB.
interface des_if;
  logic        start;
  logic        enc_dec;
  logic [1:64] in;
  logic [1:64] key;
  logic [1:64] out;
  logic        busy;
  logic        done;

  modport master (output start, enc_dec, in, key, input out, busy, done);
  modport slave  (input start, enc_dec, in, key, output out, busy, done);
endinterface

// File: rtl/des.sv
// Iterative DES encrypt/decrypt engine, one Feistel round per clock.
// Decryption walks the key schedule backwards by rotating C/D right.
module des (
  input  logic clk,
  input  logic rst_n,
  des_if.slave bus
);

  typedef enum logic {IDLE, ROUND} state_t;

  localparam int IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [0:47] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Each S-box is 64 nibbles, row-major, entry (row*16+col) starting at the MSB.
  localparam logic [255:0] SBOX [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [1:64] permIp(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[IP_T[i]];
    return y;
  endfunction

  function automatic logic [1:64] permFp(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[FP_T[i]];
    return y;
  endfunction

  function automatic logic [1:48] permE(input logic [1:32] x);
    logic [1:48] y;
    for (int i = 0; i < 48; i++) y[i+1] = x[E_T[i]];
    return y;
  endfunction

  function automatic logic [1:32] permP(input logic [1:32] x);
    logic [1:32] y;
    for (int i = 0; i < 32; i++) y[i+1] = x[P_T[i]];
    return y;
  endfunction

  function automatic logic [1:56] permPc1(input logic [1:64] x);
    logic [1:56] y;
    for (int i = 0; i < 56; i++) y[i+1] = x[PC1_T[i]];
    return y;
  endfunction

  function automatic logic [1:48] permPc2(input logic [1:56] x);
    logic [1:48] y;
    for (int i = 0; i < 48; i++) y[i+1] = x[PC2_T[i]];
    return y;
  endfunction

  function automatic logic [1:32] feistel(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:6]  b;
    logic [5:0]  idx;
    logic [1:32] s;
    x = permE(r) ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b = x[6*j+1 +: 6];
      idx = {b[1], b[6], b[2:5]};
      s[4*j+1 +: 4] = SBOX[j][255 - 4*int'(idx) -: 4];
    end
    return permP(s);
  endfunction

  function automatic logic [1:28] rotLeft(input logic [1:28] x, input logic [1:0] n);
    case (n)
      2'd1:    rotLeft = {x[2:28], x[1]};
      2'd2:    rotLeft = {x[3:28], x[1:2]};
      default: rotLeft = x;
    endcase
  endfunction

  function automatic logic [1:28] rotRight(input logic [1:28] x, input logic [1:0] n);
    case (n)
      2'd1:    rotRight = {x[28], x[1:27]};
      2'd2:    rotRight = {x[27:28], x[1:26]};
      default: rotRight = x;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_nextState;
  logic        w_accept;
  logic        w_last;
  logic [1:32] r_l;
  logic [1:32] r_r;
  logic [1:28] r_c;
  logic [1:28] r_d;
  logic [4:0]  r_round;
  logic        r_encDec;
  logic [1:64] r_out;
  logic        r_done;
  logic [1:0]  w_shift;
  logic [1:28] w_c;
  logic [1:28] w_d;
  logic [1:48] w_subKey;
  logic [1:32] w_newL;
  logic [1:32] w_newR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_nextState = ROUND;
        end
      end
      ROUND: begin
        if (r_round == 5'd16) begin
          w_last      = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Decrypt skips the rotation in round 1: C16/D16 equal C0/D0, which yields K16 directly.
  always_comb begin
    w_shift = 2'd2;
    if (r_round == 5'd1 || r_round == 5'd2 || r_round == 5'd9 || r_round == 5'd16)
      w_shift = 2'd1;
    if (!r_encDec && r_round == 5'd1)
      w_shift = 2'd0;
    w_c      = r_encDec ? rotLeft(r_c, w_shift) : rotRight(r_c, w_shift);
    w_d      = r_encDec ? rotLeft(r_d, w_shift) : rotRight(r_d, w_shift);
    w_subKey = permPc2({w_c, w_d});
    w_newL   = r_r;
    w_newR   = r_l ^ feistel(r_r, w_subKey);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l      <= '0;
      r_r      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_round  <= '0;
      r_encDec <= 1'b0;
      r_out    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        {r_l, r_r} <= permIp(bus.in);
        {r_c, r_d} <= permPc1(bus.key);
        r_encDec   <= bus.enc_dec;
        r_round    <= 5'd1;
      end else if (r_state == ROUND) begin
        r_l     <= w_newL;
        r_r     <= w_newR;
        r_c     <= w_c;
        r_d     <= w_d;
        r_round <= w_last ? 5'd0 : r_round + 5'd1;
        if (w_last) r_out <= permFp({w_newR, w_newL});
      end
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = (r_state == ROUND);
  assign bus.done = r_done;

endmodule

// File: tb/tb_des.sv
// Directed-vector bench for the des engine: known answers, parity, handshake and reset abort.
module tb_des;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  des_if bus ();

  des dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Runs one operation; returns the result, edges from acceptance to done,
  // busy just after acceptance and done one edge after it first rose.
  task automatic applyStimulus(input logic [63:0] key, input logic [63:0] data, input logic encDec,
                               output logic [63:0] result, output int latency,
                               output logic busyAfter, output logic doneAfter);
    @(negedge clk);
    bus.key     = key;
    bus.in      = data;
    bus.enc_dec = encDec;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busyAfter = bus.busy;
    latency   = 0;
    while (bus.done !== 1'b1 && latency < 40) begin
      @(posedge clk);
      #1;
      latency++;
    end
    result = bus.out;
    @(posedge clk);
    #1;
    doneAfter = bus.done;
  endtask

  logic [63:0] res;
  logic [63:0] back;
  logic [63:0] rk;
  logic [63:0] rp;
  int          lat;
  int          cycles;
  int          doneCount;
  logic        busyA;
  logic        doneA;

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.enc_dec = 1'b0;
    bus.in      = '0;
    bus.key     = '0;
    #22;
    checkOutput("reset out", bus.out, 64'h0);
    checkOutput("reset busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("reset done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1, res, lat, busyA, doneA);
    checkOutput("enc busy after accept", {63'd0, busyA}, 64'd1);
    checkOutput("enc latency", 64'(lat), 64'd16);
    checkOutput("enc result", res, 64'h85E813540F0AB405);
    checkOutput("enc done drops", {63'd0, doneA}, 64'd0);
    checkOutput("enc busy after done", {63'd0, bus.busy}, 64'd0);

    applyStimulus(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0, res, lat, busyA, doneA);
    checkOutput("dec latency", 64'(lat), 64'd16);
    checkOutput("dec result", res, 64'h0123456789ABCDEF);

    applyStimulus(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b1, res, lat, busyA, doneA);
    checkOutput("kat 8787", res, 64'h0000000000000000);

    applyStimulus(64'h0000000000000000, 64'h0000000000000000, 1'b1, res, lat, busyA, doneA);
    checkOutput("kat zero", res, 64'h8CA64DE9C1B123A7);

    applyStimulus(64'h133457799BBCDFF1 ^ 64'h0101010101010101, 64'h0123456789ABCDEF, 1'b1,
                  res, lat, busyA, doneA);
    checkOutput("parity ignored", res, 64'h85E813540F0AB405);

    // start stays high and inputs change while busy; only the accepted block matters
    @(negedge clk);
    bus.key     = 64'h0;
    bus.in      = 64'h0;
    bus.enc_dec = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.key     = 64'h133457799BBCDFF1;
    bus.in      = 64'h0123456789ABCDEF;
    bus.enc_dec = 1'b0;
    cycles      = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 8) checkOutput("out held mid-op", bus.out, 64'h85E813540F0AB405);
    end
    bus.start = 1'b0;
    doneCount = (bus.done === 1'b1) ? 1 : 0;
    checkOutput("held-start latency", 64'(cycles), 64'd16);
    checkOutput("held-start result", bus.out, 64'h8CA64DE9C1B123A7);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneCount++;
    end
    checkOutput("single done pulse", 64'(doneCount), 64'd1);

    for (int i = 0; i < 3; i++) begin
      rk = {$urandom, $urandom};
      rp = {$urandom, $urandom};
      applyStimulus(rk, rp, 1'b1, res, lat, busyA, doneA);
      applyStimulus(rk, res, 1'b0, back, lat, busyA, doneA);
      checkOutput($sformatf("round trip %0d", i), back, rp);
    end

    // abort in the middle of round 8
    @(negedge clk);
    bus.key     = 64'h133457799BBCDFF1;
    bus.in      = 64'h0123456789ABCDEF;
    bus.enc_dec = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort out", bus.out, 64'h0);
    checkOutput("abort busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("abort done", {63'd0, bus.done}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    doneCount = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneCount++;
    end
    checkOutput("no done after abort", 64'(doneCount), 64'd0);
    checkOutput("out still cleared", bus.out, 64'h0);

    applyStimulus(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1, res, lat, busyA, doneA);
    checkOutput("enc after reset", res, 64'h85E813540F0AB405);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
